// File: rtl/xcel_mult_responder.sv
// Accelerator-side responder for the xcel val/rdy interface: three operand/result
// registers and an iterative 32-cycle shift-add multiplier started by a write to addr 0.
module xcel_mult_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic [45:0] xcel_reqstream_msg,
  input  logic        xcel_reqstream_val,
  output logic        xcel_reqstream_rdy,
  output logic [40:0] xcel_respstream_msg,
  output logic        xcel_respstream_val,
  input  logic        xcel_respstream_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic [31:0] xr1_r;
  logic [31:0] xr2_r;
  logic [31:0] result_r;
  logic [31:0] mcand_r;
  logic [31:0] mplier_r;
  logic [31:0] acc_r;
  logic [31:0] acc_next_s;
  logic [4:0]  cnt_r;
  logic [7:0]  go_opaque_r;

  logic        req_rdy_r;
  logic        resp_val_r;
  logic [40:0] resp_msg_r;
  logic [40:0] resp_msg_next_s;

  logic [7:0]  req_opaque_s;
  logic        req_type_s;
  logic [4:0]  req_addr_s;
  logic [31:0] req_data_s;
  logic        req_xfer_s;
  logic        req_go_s;
  logic        calc_done_s;
  logic [31:0] read_data_s;

  // Register-file read port: addr 0 is the result, 1/2 the operands, anything else reads 0.
  function automatic logic [31:0] read_mux(input logic [4:0]  addr,
                                           input logic [31:0] r0,
                                           input logic [31:0] r1,
                                           input logic [31:0] r2);
    case (addr)
      5'd0:    read_mux = r0;
      5'd1:    read_mux = r1;
      5'd2:    read_mux = r2;
      default: read_mux = 32'd0;
    endcase
  endfunction

  assign req_opaque_s = xcel_reqstream_msg[45:38];
  assign req_type_s   = xcel_reqstream_msg[37];
  assign req_addr_s   = xcel_reqstream_msg[36:32];
  assign req_data_s   = xcel_reqstream_msg[31:0];

  assign req_xfer_s   = xcel_reqstream_val && req_rdy_r;
  assign req_go_s     = req_type_s && (req_addr_s == 5'd0);
  assign calc_done_s  = (state_r == CALC) && (cnt_r == 5'd31);
  assign acc_next_s   = acc_r + (mplier_r[0] ? mcand_r : 32'd0);
  assign read_data_s  = read_mux(req_addr_s, result_r, xr1_r, xr2_r);

  assign xcel_reqstream_rdy  = req_rdy_r;
  assign xcel_respstream_val = resp_val_r;
  assign xcel_respstream_msg = resp_msg_r;

  // Next-state and next response message; the message is zero in every state but RESP.
  always_comb begin
    state_next_s    = state_r;
    resp_msg_next_s = 41'd0;
    case (state_r)
      IDLE: begin
        if (req_xfer_s && req_go_s) begin
          state_next_s = CALC;
        end else if (req_xfer_s) begin
          state_next_s    = RESP;
          resp_msg_next_s = {req_opaque_s, req_type_s,
                             (req_type_s ? 32'd0 : read_data_s)};
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (calc_done_s) begin
          state_next_s    = RESP;
          resp_msg_next_s = {go_opaque_r, 1'b1, 32'd0};
        end else begin
          state_next_s = CALC;
        end
      end
      RESP: begin
        if (xcel_respstream_rdy) begin
          state_next_s = IDLE;
        end else begin
          state_next_s    = RESP;
          resp_msg_next_s = resp_msg_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register and registered handshake outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      req_rdy_r  <= 1'b1;
      resp_val_r <= 1'b0;
      resp_msg_r <= 41'd0;
    end else begin
      state_r    <= state_next_s;
      req_rdy_r  <= (state_next_s == IDLE);
      resp_val_r <= (state_next_s == RESP);
      resp_msg_r <= resp_msg_next_s;
    end
  end

  // Architectural registers xr1/xr2; writes to any other nonzero address are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      xr1_r <= 32'd0;
      xr2_r <= 32'd0;
    end else if (req_xfer_s && req_type_s) begin
      case (req_addr_s)
        5'd1:    xr1_r <= req_data_s;
        5'd2:    xr2_r <= req_data_s;
        default: begin
          xr1_r <= xr1_r;
          xr2_r <= xr2_r;
        end
      endcase
    end
  end

  // Shift-add multiplier: operands latched at go, one multiplier bit per CALC cycle, LSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r     <= 32'd0;
      mplier_r    <= 32'd0;
      acc_r       <= 32'd0;
      cnt_r       <= 5'd0;
      result_r    <= 32'd0;
      go_opaque_r <= 8'd0;
    end else if (req_xfer_s && req_go_s) begin
      mcand_r     <= xr1_r;
      mplier_r    <= xr2_r;
      acc_r       <= 32'd0;
      cnt_r       <= 5'd0;
      go_opaque_r <= req_opaque_s;
    end else if (state_r == CALC) begin
      mcand_r  <= {mcand_r[30:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[31:1]};
      acc_r    <= acc_next_s;
      cnt_r    <= cnt_r + 5'd1;
      if (calc_done_s) begin
        result_r <= acc_next_s;
      end
    end
  end

endmodule

// File: doc/xcel_mult_responder.md
XCEL_MULT_RESPONDER -- requirements
Module: xcel_mult_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port xcel_reqstream_msg, input, xcel_req_t (46 bits): opaque[7:0], type_[0:0] (0=read, 1=write), addr[4:0], data[31:0].
REQ-004 SHALL have port xcel_reqstream_val, input, 1 bit: request valid.
REQ-005 SHALL have port xcel_reqstream_rdy, output, 1 bit: request ready.
REQ-006 SHALL have port xcel_respstream_msg, output, xcel_resp_t (41 bits): opaque[7:0], type_[0:0], data[31:0].
REQ-007 SHALL have port xcel_respstream_val, output, 1 bit: response valid.
REQ-008 SHALL have port xcel_respstream_rdy, input, 1 bit: response ready.

Function
REQ-009 SHALL implement the accelerator (responder) end of the xcel val/rdy interface; a transfer occurs only in a cycle where val and rdy are both high.
REQ-010 SHALL hold architectural registers xr1 (operand A, 32 b), xr2 (operand B, 32 b), result (32 b).
REQ-011 SHALL use a 3-state FSM: IDLE, CALC, RESP.
REQ-012 IDLE: xcel_reqstream_rdy=1, xcel_respstream_val=0; all other states: reqstream_rdy=0; at most one request outstanding.
REQ-013 Write to addr 1 or 2 SHALL update xr1/xr2 with data at the accept edge, then go to RESP.
REQ-014 Write to addr 0 (go) SHALL ignore data, start an unsigned shift-add multiply of xr1*xr2 and go to CALC.
REQ-015 CALC SHALL last exactly 32 cycles (5-bit counter, one multiplier bit per cycle, LSB first); result = low 32 bits of product (identical for signed operands); then go to RESP.
REQ-016 Read addr 0 returns result; addr 1 returns xr1; addr 2 returns xr2; any other addr returns 0; writes to addr 3-31 are ignored but still answered.
REQ-017 Read data SHALL be captured at the accept edge.
REQ-018 RESP: xcel_respstream_val=1; msg.opaque and msg.type_ echo the accepted request; msg.data = read data for reads, 0 for writes.
REQ-019 RESP SHALL hold msg stable until xcel_respstream_rdy=1, then return to IDLE on that edge.
REQ-020 Latency: request accepted at edge T -> response valid in cycle after T (non-go) or after T+32 edges, i.e. 33rd cycle after acceptance (go).
REQ-021 New request SHALL not be accepted in the same cycle a response is delivered (IDLE only).
REQ-022 xcel_respstream_msg SHALL be all zeros whenever xcel_respstream_val=0.
REQ-023 Back-to-back go writes SHALL each recompute from current xr1/xr2.
REQ-024 xr1/xr2 written before go SHALL be used; operands latched into shift registers at go acceptance.

Reset
REQ-025 reset SHALL force state IDLE, xr1=xr2=result=0, counter=0, reqstream_rdy=1 (cycle after reset deasserts), respstream_val=0.
REQ-026 Reset asserted during CALC or RESP SHALL abort the operation and drop any pending response.

Verification
REQ-027 Write xr1=6 (opaque 0x11), write xr2=7, write xr0, read xr0 -> four responses in order with opaques echoed; write data 0; read returns 42; go response 33 cycles after acceptance.
REQ-028 xr1=0xFFFFFFFF, xr2=0xFFFFFFFF, go, read xr0 -> 0x00000001; xr1=0x80000000, xr2=2 -> 0x00000000.
REQ-029 Response backpressure: respstream_rdy low 5 cycles during RESP -> val stays 1, msg stable, reqstream_rdy stays 0; completes on rdy.
REQ-030 Read addr 7 -> data 0; write addr 9 data 0x55 then read xr1/xr2 -> unchanged values.
REQ-031 Reset asserted at CALC cycle 10 -> no response emitted; read xr0 after reset -> 0.
REQ-032 Random stream of 200 requests with random val/rdy gaps -> responses match golden model, one per request, in order, msg zero when val low.
